mem_req_stage: RTL and testbench
================================

Name: mem_req_stage

Overview:
- Parametrised successor of the current MEM pipeline stage.
- Replaces the fixed single-cycle SRAM access with a split request/response handshake (req/addr_ok/data_ok) toward the data cache or bridge.
- Adds configurable data width, load byte/halfword extraction in-stage, and flush-safe discarding of in-flight responses.
- Sits between EXE and WB and keeps the existing valid/allowin pipeline handshake.

Parameters:
- DATA_W, 32, data bus width; legal values are 32 or 64.
- ADDR_W, 32, address width.
- MAX_DISCARD, 3, maximum number of flushed-but-outstanding responses tracked (counter saturation bound).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- flush_i  in  1  WB exception/eret clear; kills the instruction in MEM.
- exe_valid_i  in  1  EXE has an instruction for MEM.
- mem_allowin_o  out  1  MEM can accept an instruction this cycle.
- exe_pc_i  in  ADDR_W  instruction PC.
- exe_addr_i  in  ADDR_W  memory virtual/physical address (already mapped).
- exe_result_i  in  DATA_W  ALU/NNPC result for non-load instructions.
- exe_rd_i  in  1  instruction is a load.
- exe_wr_i  in  1  instruction is a store.
- exe_wstrb_i  in  DATA_W/8  store byte strobes, already lane-aligned.
- exe_wdata_i  in  DATA_W  store data, already lane-aligned.
- exe_load_op_i  in  3  0=LW, 1=LB, 2=LBU, 3=LH, 4=LHU; 5-7 behave as LW.
- exe_wnum_i  in  5  destination register.
- exe_except_i  in  1  exception already raised upstream.
- wb_allowin_i  in  1  WB accepts.
- mem_valid_o  out  1  MEM result valid for WB.
- mem_pc_o  out  ADDR_W  registered PC.
- mem_wnum_o  out  5  registered destination.
- mem_except_o  out  1  registered exception flag.
- mem_result_o  out  DATA_W  writeback data.
- req_o  out  1  cache request valid.
- req_wr_o  out  1  1 = write request.
- req_addr_o  out  ADDR_W  request address.
- req_wstrb_o  out  DATA_W/8  write strobes.
- req_wdata_o  out  DATA_W  write data.
- addr_ok_i  in  1  request accepted.
- data_ok_i  in  1  response returned; responses arrive in order.
- rdata_i  in  DATA_W  read data, valid with data_ok_i.

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, discard_cnt=0, all outputs and registered fields 0.
- States:
  - IDLE: empty.
  - REQ: req_o=1, awaiting addr_ok.
  - RESP: awaiting data_ok.
  - DONE: result held for WB.
- Capture: exe_valid_i && mem_allowin_o && !flush_i latches all exe_* fields.
  - Next state REQ if (exe_rd_i|exe_wr_i) && !exe_except_i; else DONE with mem_result_o=exe_result_i.
  - Exception instructions never issue a request, so no store side effect.
- mem_allowin_o = (state==IDLE) | (state==DONE & wb_allowin_i) | flush_i.
- REQ: req_o, req_wr_o, req_addr_o, req_wstrb_o and req_wdata_o are driven from registers and held stable until addr_ok_i.
  - Issue is gated while discard_cnt==MAX_DISCARD.
  - addr_ok_i moves the state to RESP.
  - req_wstrb_o=0 for loads.
- RESP: data_ok_i with discard_cnt==0 moves the state to DONE.
  - Loads: mem_result_o = extracted data. Stores: mem_result_o = 0.
  - A data_ok_i with discard_cnt>0 decrements discard_cnt and is not delivered.
- Minimum load latency: capture at cycle 0, req_o at cycle 1, earliest mem_valid_o at cycle 3 (addr_ok at 1, data_ok at 2).
- Load extraction:
  - Lane select: DATA_W=64 uses addr[2] to pick the 32-bit word.
  - Byte/half select: addr[1:0] for bytes, addr[1] for halves.
  - Sign extension: LB/LH sign-extend to DATA_W; LBU/LHU zero-extend.
  - Misalignment is flagged upstream via exe_except_i.
- mem_valid_o = (state==DONE) & !flush_i. Leaving DONE happens only on wb_allowin_i or flush_i.
- Flush:
  - All states go to IDLE next cycle.
  - REQ without addr_ok: request withdrawn, no count.
  - REQ with addr_ok in the same cycle: the request is accepted, discard_cnt+1.
  - RESP without data_ok: discard_cnt+1.
  - RESP with data_ok and discard_cnt==0: response consumed, no count.
- Simultaneous flush and exe_valid_i: flush wins and nothing is captured.
- Simultaneous data_ok discard-decrement and flush-increment: net count unchanged.
- discard_cnt saturates at MAX_DISCARD and never wraps.
- A new request may issue while discard_cnt>0; ordering guarantees its response follows the discarded ones.
- Reset mid-transaction returns to IDLE with discard_cnt=0; the cache side is reset together.

Test Plan:
- LW at 0x1000, addr_ok at cycle 1, data_ok at cycle 3 with rdata 0x8899AABB -> mem_valid_o at cycle 4, mem_result_o=0x8899AABB, req_wr_o=0.
- LB then LBU at addr 0x1003, rdata 0x80112233 -> results 0xFFFFFF80 then 0x00000080; repeat with DATA_W=64 and addr 0x1004 to check upper-word select.
- SW with exe_except_i=1 -> req_o never asserts, mem_valid_o=1 next cycle with mem_except_o=1.
- Load in RESP, flush_i pulsed, new LW issued before the old data_ok -> first data_ok dropped (discard_cnt 1->0), second data_ok delivers the new data.
- Three flushes with outstanding responses (MAX_DISCARD=3) -> discard_cnt=3, next req_o held low until a data_ok decrements.
- wb_allowin_i=0 for 4 cycles in DONE -> mem_allowin_o=0, outputs stable, no new capture.

Source files
------------

// File: rtl/mem_req_stage.sv
// mem_req_stage: MEM pipeline stage with a split request/response handshake
// toward the data cache. An instruction is captured from EXE, issues at most
// one cache request, waits for its in-order response, extracts load data and
// holds the result for WB. Responses still in flight when the stage is
// flushed are counted and silently dropped when they come back.

module mem_req_stage #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int MAX_DISCARD = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  exe_valid_i,
  output logic                  mem_allowin_o,
  input  logic [ADDR_W-1:0]     exe_pc_i,
  input  logic [ADDR_W-1:0]     exe_addr_i,
  input  logic [DATA_W-1:0]     exe_result_i,
  input  logic                  exe_rd_i,
  input  logic                  exe_wr_i,
  input  logic [DATA_W/8-1:0]   exe_wstrb_i,
  input  logic [DATA_W-1:0]     exe_wdata_i,
  input  logic [2:0]            exe_load_op_i,
  input  logic [4:0]            exe_wnum_i,
  input  logic                  exe_except_i,
  input  logic                  wb_allowin_i,
  output logic                  mem_valid_o,
  output logic [ADDR_W-1:0]     mem_pc_o,
  output logic [4:0]            mem_wnum_o,
  output logic                  mem_except_o,
  output logic [DATA_W-1:0]     mem_result_o,
  output logic                  req_o,
  output logic                  req_wr_o,
  output logic [ADDR_W-1:0]     req_addr_o,
  output logic [DATA_W/8-1:0]   req_wstrb_o,
  output logic [DATA_W-1:0]     req_wdata_o,
  input  logic                  addr_ok_i,
  input  logic                  data_ok_i,
  input  logic [DATA_W-1:0]     rdata_i
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(MAX_DISCARD + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_DISCARD);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] OP_LB  = 3'd1;
  localparam logic [2:0] OP_LBU = 3'd2;
  localparam logic [2:0] OP_LH  = 3'd3;
  localparam logic [2:0] OP_LHU = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]  discard_cnt;
  logic [ADDR_W-1:0] pc_q, addr_q;
  logic [4:0]        wnum_q;
  logic              except_q, rd_q, wr_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [DATA_W-1:0] wdata_q, result_q;
  logic [2:0]        load_op_q;

  logic              capture, cap_mem, addr_acc, resp_take, resp_drop, cnt_inc;
  logic [31:0]       word_sel;
  logic [DATA_W-1:0] load_data;

  // Extract the addressed byte/half/word of a 32-bit word and extend it.
  function automatic logic [DATA_W-1:0] extract(input logic [31:0] w,
                                                input logic [1:0]  ofs,
                                                input logic [2:0]  op);
    logic [7:0]  b;
    logic [15:0] h;
    case (ofs)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      2'd3:    b = w[31:24];
      default: b = w[7:0];
    endcase
    h = ofs[1] ? w[31:16] : w[15:0];
    case (op)
      OP_LB:   extract = DATA_W'($signed(b));
      OP_LBU:  extract = DATA_W'(b);
      OP_LH:   extract = DATA_W'($signed(h));
      OP_LHU:  extract = DATA_W'(h);
      default: extract = DATA_W'($signed(w));
    endcase
  endfunction

  // On a 64-bit bus address bit 2 selects which 32-bit word holds the load.
  if (DATA_W == 64) begin : g_lane64
    assign word_sel = addr_q[2] ? rdata_i[DATA_W-1:32] : rdata_i[31:0];
  end else begin : g_lane32
    assign word_sel = rdata_i[31:0];
  end

  assign load_data = extract(word_sel, addr_q[1:0], load_op_q);

  // Handshake and request outputs derived from the state and discard count.
  always_comb begin
    mem_allowin_o = (state == IDLE) | ((state == DONE) & wb_allowin_i) | flush_i;
    mem_valid_o   = (state == DONE) & ~flush_i;
    req_o         = (state == REQ) & (discard_cnt != CNT_MAX);
    capture       = exe_valid_i & mem_allowin_o & ~flush_i;
    cap_mem       = (exe_rd_i | exe_wr_i) & ~exe_except_i;
    addr_acc      = req_o & addr_ok_i;
    resp_take     = (state == RESP) & data_ok_i & (discard_cnt == CNT_ZERO);
    resp_drop     = data_ok_i & (discard_cnt != CNT_ZERO);
    cnt_inc       = flush_i & (((state == REQ) & addr_acc) |
                               ((state == RESP) & ~resp_take));
  end

  // Next-state selection; a flush always empties the stage.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (capture) state_nxt = cap_mem ? REQ : DONE;
        else         state_nxt = IDLE;
      end
      REQ: begin
        if (addr_acc) state_nxt = RESP;
        else          state_nxt = REQ;
      end
      RESP: begin
        if (resp_take) state_nxt = DONE;
        else           state_nxt = RESP;
      end
      DONE: begin
        if (capture)           state_nxt = cap_mem ? REQ : DONE;
        else if (wb_allowin_i) state_nxt = IDLE;
        else                   state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush_i) state_nxt = IDLE;
    else         state_nxt = state_nxt;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Saturating count of flushed responses still owed by the cache.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      discard_cnt <= CNT_ZERO;
    end else if (cnt_inc && !resp_drop) begin
      if (discard_cnt != CNT_MAX) discard_cnt <= discard_cnt + CNT_ONE;
    end else if (resp_drop && !cnt_inc) begin
      discard_cnt <= discard_cnt - CNT_ONE;
    end
  end

  // Instruction fields captured from EXE and the result delivered to WB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q      <= {ADDR_W{1'b0}};
      addr_q    <= {ADDR_W{1'b0}};
      wnum_q    <= 5'd0;
      except_q  <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      wstrb_q   <= {STRB_W{1'b0}};
      wdata_q   <= {DATA_W{1'b0}};
      load_op_q <= 3'd0;
      result_q  <= {DATA_W{1'b0}};
    end else if (capture) begin
      pc_q      <= exe_pc_i;
      addr_q    <= exe_addr_i;
      wnum_q    <= exe_wnum_i;
      except_q  <= exe_except_i;
      rd_q      <= exe_rd_i;
      wr_q      <= exe_wr_i;
      wstrb_q   <= exe_wr_i ? exe_wstrb_i : {STRB_W{1'b0}};
      wdata_q   <= exe_wdata_i;
      load_op_q <= exe_load_op_i;
      result_q  <= cap_mem ? {DATA_W{1'b0}} : exe_result_i;
    end else if (resp_take && !flush_i) begin
      result_q  <= rd_q ? load_data : {DATA_W{1'b0}};
    end
  end

  assign mem_pc_o     = pc_q;
  assign mem_wnum_o   = wnum_q;
  assign mem_except_o = except_q;
  assign mem_result_o = result_q;
  assign req_wr_o     = wr_q;
  assign req_addr_o   = addr_q;
  assign req_wstrb_o  = wstrb_q;
  assign req_wdata_o  = wdata_q;

endmodule

// File: tb/tb_mem_req_stage.sv
// Directed testbench for mem_req_stage: a 32-bit and a 64-bit instance run
// the same control sequence; expected values are hand-computed constants.

module tb_mem_req_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, exe_valid, exe_rd, exe_wr, exe_except;
  logic        wb_allowin, addr_ok, data_ok;
  logic [31:0] exe_pc, exe_addr, exe_result, exe_wdata, rdata;
  logic [3:0]  exe_wstrb;
  logic [2:0]  load_op;
  logic [4:0]  exe_wnum;
  logic [63:0] exe_result64, exe_wdata64, rdata64;
  logic [7:0]  exe_wstrb64;

  logic        allowin, valid, except_o, req, req_wr;
  logic [31:0] pc_o, result, req_addr, req_wdata;
  logic [4:0]  wnum_o;
  logic [3:0]  req_wstrb;

  logic        allowin64, valid64, except64, req64, req_wr64;
  logic [31:0] pc64, req_addr64;
  logic [63:0] result64, req_wdata64;
  logic [4:0]  wnum64;
  logic [7:0]  req_wstrb64;

  mem_req_stage #(.DATA_W(32), .ADDR_W(32), .MAX_DISCARD(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .exe_valid_i(exe_valid),
    .mem_allowin_o(allowin), .exe_pc_i(exe_pc), .exe_addr_i(exe_addr),
    .exe_result_i(exe_result), .exe_rd_i(exe_rd), .exe_wr_i(exe_wr),
    .exe_wstrb_i(exe_wstrb), .exe_wdata_i(exe_wdata), .exe_load_op_i(load_op),
    .exe_wnum_i(exe_wnum), .exe_except_i(exe_except), .wb_allowin_i(wb_allowin),
    .mem_valid_o(valid), .mem_pc_o(pc_o), .mem_wnum_o(wnum_o),
    .mem_except_o(except_o), .mem_result_o(result), .req_o(req),
    .req_wr_o(req_wr), .req_addr_o(req_addr), .req_wstrb_o(req_wstrb),
    .req_wdata_o(req_wdata), .addr_ok_i(addr_ok), .data_ok_i(data_ok),
    .rdata_i(rdata)
  );

  mem_req_stage #(.DATA_W(64), .ADDR_W(32), .MAX_DISCARD(3)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .exe_valid_i(exe_valid),
    .mem_allowin_o(allowin64), .exe_pc_i(exe_pc), .exe_addr_i(exe_addr),
    .exe_result_i(exe_result64), .exe_rd_i(exe_rd), .exe_wr_i(exe_wr),
    .exe_wstrb_i(exe_wstrb64), .exe_wdata_i(exe_wdata64), .exe_load_op_i(load_op),
    .exe_wnum_i(exe_wnum), .exe_except_i(exe_except), .wb_allowin_i(wb_allowin),
    .mem_valid_o(valid64), .mem_pc_o(pc64), .mem_wnum_o(wnum64),
    .mem_except_o(except64), .mem_result_o(result64), .req_o(req64),
    .req_wr_o(req_wr64), .req_addr_o(req_addr64), .req_wstrb_o(req_wstrb64),
    .req_wdata_o(req_wdata64), .addr_ok_i(addr_ok), .data_ok_i(data_ok),
    .rdata_i(rdata64)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single cycle.
  task automatic issue(input logic rd, input logic wr, input logic [2:0] op,
                       input logic [31:0] addr);
    exe_valid = 1'b1; exe_rd = rd; exe_wr = wr; load_op = op; exe_addr = addr;
    exe_pc = addr + 32'h0000_0100;
    tick();
    exe_valid = 1'b0; exe_rd = 1'b0; exe_wr = 1'b0;
  endtask

  // Full load with zero-wait handshakes; leaves the stage in DONE.
  task automatic load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                      input logic [31:0] r32, input logic [63:0] r64);
    int n;
    issue(1'b1, 1'b0, op, addr);
    n = 0;
    while (!req && n < 20) begin tick(); n++; end
    check({tag, "_req"}, {63'd0, req}, 64'd1);
    addr_ok = 1'b1; tick(); addr_ok = 1'b0;
    data_ok = 1'b1; rdata = r32; rdata64 = r64; tick(); data_ok = 1'b0;
    check({tag, "_valid"}, {63'd0, valid}, 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; exe_valid = 1'b0; exe_rd = 1'b0; exe_wr = 1'b0;
    exe_except = 1'b0; wb_allowin = 1'b1; addr_ok = 1'b0; data_ok = 1'b0;
    exe_pc = 32'd0; exe_addr = 32'd0; exe_result = 32'd0; exe_wdata = 32'd0;
    rdata = 32'd0; exe_wstrb = 4'hF; load_op = 3'd0; exe_wnum = 5'd7;
    exe_result64 = 64'd0; exe_wdata64 = 64'd0; rdata64 = 64'd0; exe_wstrb64 = 8'h0F;

    tick(); tick();
    check("rst_valid",   {63'd0, valid},    64'd0);
    check("rst_req",     {63'd0, req},      64'd0);
    check("rst_result",  {32'd0, result},   64'd0);
    check("rst_pc",      {32'd0, pc_o},     64'd0);
    check("rst_allowin", {63'd0, allowin},  64'd1);
    rst_n = 1'b1;

    // LW 0x1000: addr_ok in cycle 1, data_ok in cycle 3, valid in cycle 4.
    issue(1'b1, 1'b0, 3'd0, 32'h0000_1000);
    check("lw_req",   {63'd0, req},       64'd1);
    check("lw_wr",    {63'd0, req_wr},    64'd0);
    check("lw_addr",  {32'd0, req_addr},  64'h1000);
    check("lw_wstrb", {60'd0, req_wstrb}, 64'd0);
    addr_ok = 1'b1; tick(); addr_ok = 1'b0;
    check("lw_req_drop", {63'd0, req}, 64'd0);
    tick();
    check("lw_wait_valid", {63'd0, valid}, 64'd0);
    data_ok = 1'b1; rdata = 32'h8899_AABB; tick(); data_ok = 1'b0;
    check("lw_valid",  {63'd0, valid},   64'd1);
    check("lw_result", {32'd0, result},  64'h8899_AABB);
    check("lw_wnum",   {59'd0, wnum_o},  64'd7);
    tick();
    check("lw_leave", {63'd0, valid}, 64'd0);

    // Byte/half extraction, with the 64-bit instance picking lanes by addr[2].
    load("lb3", 3'd1, 32'h0000_1003, 32'h8011_2233, 64'h0000_0000_8011_2233);
    check("lb3_r32", {32'd0, result}, 64'h0000_0000_FFFF_FF80);
    check("lb3_r64", result64,        64'hFFFF_FFFF_FFFF_FF80);
    tick();
    load("lbu3", 3'd2, 32'h0000_1003, 32'h8011_2233, 64'h0000_0000_8011_2233);
    check("lbu3_r32", {32'd0, result}, 64'h80);
    tick();
    load("lb7", 3'd1, 32'h0000_1007, 32'h8011_2233, 64'h8011_2233_7F44_5566);
    check("lb7_r64", result64, 64'hFFFF_FFFF_FFFF_FF80);
    tick();
    load("lbu7", 3'd2, 32'h0000_1007, 32'h8011_2233, 64'h8011_2233_7F44_5566);
    check("lbu7_r64", result64, 64'h80);
    tick();
    load("lb4", 3'd1, 32'h0000_1004, 32'h0000_0011, 64'h1234_5681_0000_0000);
    check("lb4_r64", result64, 64'hFFFF_FFFF_FFFF_FF81);
    tick();
    load("lh2", 3'd3, 32'h0000_1002, 32'h8011_2233, 64'h0);
    check("lh2_r32", {32'd0, result}, 64'hFFFF_8011);
    tick();
    load("lhu2", 3'd4, 32'h0000_1002, 32'h8011_2233, 64'h0);
    check("lhu2_r32", {32'd0, result}, 64'h8011);
    tick();
    load("lh0", 3'd3, 32'h0000_1000, 32'h8011_7233, 64'h0);
    check("lh0_r32", {32'd0, result}, 64'h7233);
    tick();

    // Store request held stable while addr_ok is withheld.
    exe_wstrb = 4'h3; exe_wdata = 32'hDEAD_BEEF;
    issue(1'b0, 1'b1, 3'd0, 32'h0000_2000);
    tick();
    check("sw_req",   {63'd0, req},       64'd1);
    check("sw_wr",    {63'd0, req_wr},    64'd1);
    check("sw_addr",  {32'd0, req_addr},  64'h2000);
    check("sw_wstrb", {60'd0, req_wstrb}, 64'h3);
    check("sw_wdata", {32'd0, req_wdata}, 64'hDEAD_BEEF);
    addr_ok = 1'b1; tick(); addr_ok = 1'b0;
    data_ok = 1'b1; rdata = 32'hFFFF_FFFF; tick(); data_ok = 1'b0;
    check("sw_valid",  {63'd0, valid},  64'd1);
    check("sw_result", {32'd0, result}, 64'd0);
    tick();

    // Store carrying an upstream exception never issues.
    exe_result = 32'h0000_1234; exe_except = 1'b1;
    issue(1'b0, 1'b1, 3'd0, 32'h0000_2004);
    exe_except = 1'b0;
    check("exc_req",    {63'd0, req},      64'd0);
    check("exc_valid",  {63'd0, valid},    64'd1);
    check("exc_flag",   {63'd0, except_o}, 64'd1);
    check("exc_result", {32'd0, result},   64'h1234);
    tick();
    check("exc_req2", {63'd0, req}, 64'd0);

    // Flush and new instruction in the same cycle: nothing captured.
    flush = 1'b1; exe_valid = 1'b1; exe_rd = 1'b1; tick();
    flush = 1'b0; exe_valid = 1'b0; exe_rd = 1'b0;
    check("fv_req",   {63'd0, req},   64'd0);
    check("fv_valid", {63'd0, valid}, 64'd0);

    // Flush in RESP; the stale response is dropped, the new one delivered.
    issue(1'b1, 1'b0, 3'd0, 32'h0000_3000);
    addr_ok = 1'b1; tick(); addr_ok = 1'b0;
    flush = 1'b1; #1;
    check("fl_allowin", {63'd0, allowin}, 64'd1);
    tick(); flush = 1'b0;
    issue(1'b1, 1'b0, 3'd0, 32'h0000_3004);
    check("fl_req_new", {63'd0, req}, 64'd1);
    addr_ok = 1'b1; tick(); addr_ok = 1'b0;
    data_ok = 1'b1; rdata = 32'h1111_1111; tick();
    check("fl_drop", {63'd0, valid}, 64'd0);
    rdata = 32'h2222_2222; tick(); data_ok = 1'b0;
    check("fl_valid",  {63'd0, valid},  64'd1);
    check("fl_result", {32'd0, result}, 64'h2222_2222);
    tick();

    // Three flushed responses saturate the count and gate the next issue.
    for (int k = 0; k < 3; k++) begin
      issue(1'b1, 1'b0, 3'd0, 32'h0000_4000);
      addr_ok = 1'b1; tick(); addr_ok = 1'b0;
      flush = 1'b1; tick(); flush = 1'b0;
    end
    issue(1'b1, 1'b0, 3'd0, 32'h0000_4010);
    check("sat_gate0", {63'd0, req}, 64'd0);
    tick();
    check("sat_gate1", {63'd0, req}, 64'd0);
    data_ok = 1'b1; tick(); data_ok = 1'b0;
    check("sat_release", {63'd0, req}, 64'd1);
    addr_ok = 1'b1; tick(); addr_ok = 1'b0;
    data_ok = 1'b1; rdata = 32'h0BAD_0001; tick();
    check("sat_drop1", {63'd0, valid}, 64'd0);
    rdata = 32'h0BAD_0002; tick();
    check("sat_drop2", {63'd0, valid}, 64'd0);
    rdata = 32'h5A5A_5A5A; tick(); data_ok = 1'b0;
    check("sat_valid",  {63'd0, valid},  64'd1);
    check("sat_result", {32'd0, result}, 64'h5A5A_5A5A);
    tick();

    // WB stall in DONE: output held, no capture until WB accepts.
    wb_allowin = 1'b0;
    load("stall", 3'd0, 32'h0000_5000, 32'hCAFE_F00D, 64'h0);
    exe_valid = 1'b1; exe_rd = 1'b0; exe_wr = 1'b0; exe_result = 32'h0000_0777;
    exe_pc = 32'h0000_0600;
    for (int k = 0; k < 4; k++) begin
      check("stall_allowin", {63'd0, allowin}, 64'd0);
      check("stall_valid",   {63'd0, valid},   64'd1);
      check("stall_result",  {32'd0, result},  64'hCAFE_F00D);
      check("stall_pc",      {32'd0, pc_o},    64'h5100);
      tick();
    end
    wb_allowin = 1'b1; #1;
    check("stall_open", {63'd0, allowin}, 64'd1);
    tick(); exe_valid = 1'b0;
    check("stall_next_result", {32'd0, result}, 64'h0777);
    check("stall_next_pc",     {32'd0, pc_o},   64'h0600);
    check("stall_next_valid",  {63'd0, valid},  64'd1);
    tick();

    // Reset mid-transaction clears the discard count.
    issue(1'b1, 1'b0, 3'd0, 32'h0000_6000);
    addr_ok = 1'b1; tick(); addr_ok = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("mrst_req", {63'd0, req}, 64'd0);
    load("mrst", 3'd0, 32'h0000_7000, 32'h600D_D00D, 64'h0);
    check("mrst_result", {32'd0, result}, 64'h600D_D00D);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
